// File: rtl/spi_ctrl_pkg.sv
// Shared definitions for the SPI slave transaction controller.
//   stateT        : controller state encoding (3 bits)
//   SPI_WIDTH_DEF : default shift-register / data-word width
package spi_ctrl_pkg;

   localparam int unsigned SPI_WIDTH_DEF = 8;

   typedef enum logic [2:0] {
      IDLE         = 3'd0,
      GET_ADDR     = 3'd1,
      GOT_ADDR     = 3'd2,
      READ_LOAD    = 3'd3,
      READ_SEND    = 3'd4,
      WRITE_RECV   = 3'd5,
      WRITE_COMMIT = 3'd6,
      DONE         = 3'd7
   } stateT;

endpackage

// File: rtl/spi_bit_counter.sv
// Saturating bit counter for address/data phases.
//   clk     : system clock
//   resetN  : asynchronous active-low reset (count -> 0)
//   clr     : synchronous clear, priority over inc
//   inc     : increment enable; ignored once count == WIDTH
//   termCnt : high while count == WIDTH
module spi_bit_counter #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
   input  logic clk,
   input  logic resetN,
   input  logic clr,
   input  logic inc,
   output logic termCnt
);

   logic [CNT_W-1:0] count;

   assign termCnt = (count == CNT_W'(WIDTH));

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && !termCnt) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/spi_transaction_fsm.sv
// Sequencer for one SPI slave transaction: address phase, R/W decode,
// then either a read (load + shift out) or a write (shift in + commit).
//   clk         : system clock
//   resetN      : asynchronous active-low reset
//   csN         : conditioned chip select, active low
//   sclkPosEdge : one-clk pulse per SCLK rising edge
//   sclkNegEdge : one-clk pulse per SCLK falling edge
//   rwBit       : shift register bit 0 after the address phase (1 = read)
//   addrWE      : address latch enable pulse
//   srLoad      : shift register parallel-load pulse
//   dmWE        : data memory write enable pulse
//   misoBufE    : MISO tri-state enable
//   busy        : high outside IDLE
//   aborted     : registered pulse when csN rises mid-transaction
module spi_transaction_fsm
   import spi_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH = SPI_WIDTH_DEF
) (
   input  logic clk,
   input  logic resetN,
   input  logic csN,
   input  logic sclkPosEdge,
   input  logic sclkNegEdge,
   input  logic rwBit,
   output logic addrWE,
   output logic srLoad,
   output logic dmWE,
   output logic misoBufE,
   output logic busy,
   output logic aborted
);

   localparam int unsigned CNT_W = $clog2(WIDTH + 1);

   stateT state;
   stateT stateNext;
   logic  cntClr;
   logic  cntInc;
   logic  cntTc;
   logic  abortNext;

   spi_bit_counter #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) uBitCounter (
      .clk     (clk),
      .resetN  (resetN),
      .clr     (cntClr),
      .inc     (cntInc),
      .termCnt (cntTc)
   );

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state   <= IDLE;
         aborted <= 1'b0;
      end else begin
         state   <= stateNext;
         aborted <= abortNext;
      end
   end

   // Counting states leave one cycle after reaching terminal count, so the
   // counter holds WIDTH for that cycle and further pulses are dropped.
   always_comb begin
      stateNext = state;
      cntClr    = 1'b0;
      cntInc    = 1'b0;
      if (csN) begin
         stateNext = IDLE;
         cntClr    = 1'b1;
      end else begin
         case (state)
            IDLE: begin
               stateNext = GET_ADDR;
               cntClr    = 1'b1;
            end
            GET_ADDR: begin
               if (cntTc) stateNext = GOT_ADDR;
               else       cntInc    = sclkPosEdge;
            end
            GOT_ADDR: begin
               cntClr    = 1'b1;
               stateNext = rwBit ? READ_LOAD : WRITE_RECV;
            end
            READ_LOAD: stateNext = READ_SEND;
            READ_SEND: begin
               if (cntTc) stateNext = DONE;
               else       cntInc    = sclkNegEdge;
            end
            WRITE_RECV: begin
               if (cntTc) stateNext = WRITE_COMMIT;
               else       cntInc    = sclkPosEdge;
            end
            WRITE_COMMIT: stateNext = DONE;
            DONE:         stateNext = DONE;
            default:      stateNext = IDLE;
         endcase
      end
   end

   assign abortNext = csN && (state != IDLE) && (state != DONE);

   always_comb begin
      addrWE   = (state == GOT_ADDR);
      srLoad   = (state == READ_LOAD);
      dmWE     = (state == WRITE_COMMIT);
      misoBufE = (state == READ_SEND);
      busy     = (state != IDLE);
   end

endmodule

// File: doc/spi_transaction_fsm.md
Name: spi_transaction_fsm

Overview:
Controller that sequences the 8-bit shift register, address latch and data memory for one SPI slave transaction.
- It receives a conditioned chip select and one-cycle SCLK edge pulses from the input conditioners.
- It counts address/data bits and drives the shift register parallel load, address latch enable, data-memory write enable and MISO tri-state enable.
- It sits between the input conditioners and the shift-register/memory datapath in the SPI memory top level.

Parameters:
WIDTH, 8, shift register and data word width in bits (address = WIDTH-1 bits + 1 R/W bit)
CNT_W, $clog2(WIDTH+1), bit-counter width (derived, not overridden)

Ports:
clk  input  1  system clock; all state changes on rising edge
resetN  input  1  asynchronous active-low reset
csN  input  1  conditioned chip select, active low
sclkPosEdge  input  1  one-clk pulse per SCLK rising edge
sclkNegEdge  input  1  one-clk pulse per SCLK falling edge
rwBit  input  1  shift register parallelDataOut[0] (1 = read, 0 = write)
addrWE  output  1  address latch enable, one-clk pulse
srLoad  output  1  shift register parallelLoad, one-clk pulse
dmWE  output  1  data memory write enable, one-clk pulse
misoBufE  output  1  MISO tri-state buffer enable
busy  output  1  high in any state except IDLE
aborted  output  1  one-clk pulse when a transaction is cut short

Behaviour:
- Reset (resetN=0, asynchronous):
  - state = IDLE, bitCount = 0.
  - Every output is 0.
- Outputs are decoded from the registered state only (Moore), except aborted, which is a registered pulse.
- States and transitions (each arrow is taken on the next clk edge):
  - IDLE: csN=0 -> GET_ADDR, bitCount=0.
  - GET_ADDR: each sclkPosEdge increments bitCount. When bitCount reaches WIDTH (on the 8th posedge) -> GOT_ADDR.
  - GOT_ADDR (1 clk): addrWE=1, bitCount cleared. rwBit=1 -> READ_LOAD; rwBit=0 -> WRITE_RECV.
  - READ_LOAD (1 clk): srLoad=1 (memory output is combinational from the latched address) -> READ_SEND.
  - READ_SEND: misoBufE=1; each sclkNegEdge increments bitCount. On WIDTH negedges -> DONE.
  - WRITE_RECV: each sclkPosEdge increments bitCount. On WIDTH posedges -> WRITE_COMMIT.
  - WRITE_COMMIT (1 clk): dmWE=1 -> DONE.
  - DONE: all enables 0; SCLK pulses are ignored. csN=1 -> IDLE.
- Latency:
  - addrWE asserts 1 clk after the clk that registers the 8th address posedge.
  - A write's dmWE asserts 1 clk after the 8th data posedge.
- Chip-select rules:
  - csN=1 in any state forces IDLE on the next clk and clears bitCount. csN has priority over all SCLK pulses in the same cycle.
  - aborted=1 for exactly one clk when csN rises while in GET_ADDR, GOT_ADDR, READ_LOAD, READ_SEND, WRITE_RECV or WRITE_COMMIT.
  - No aborted pulse when csN rises in IDLE or DONE.
  - An aborted write never pulses dmWE.
- Edge-pulse rules:
  - Only the edge type relevant to the current state is counted. The other edge type is ignored.
  - If both pulses arrive in one cycle, only the relevant one counts.
  - bitCount never exceeds WIDTH; extra pulses in a terminal-count cycle are discarded.
- Reset asserted mid-transaction returns to IDLE immediately with all outputs 0. No aborted pulse is generated by reset.

Decomposition:
- Shared package spi_ctrl_pkg:
  - state enum (IDLE, GET_ADDR, GOT_ADDR, READ_LOAD, READ_SEND, WRITE_RECV, WRITE_COMMIT, DONE), 3-bit encoding;
  - default WIDTH constant.
- One sub-module, spi_bit_counter:
  - synchronous clear, increment enable, terminal-count output at WIDTH;
  - asynchronous active-low reset.

Test Plan:
1. Reset held low 3 clks with csN=0 and SCLK pulses -> all outputs 0, busy=0; after release with csN=0 -> GET_ADDR, busy=1 on the next clk.
2. Write: csN=0, 8 posedges with rwBit=0 at the 8th -> addrWE single pulse. Then 8 posedges -> dmWE single pulse, misoBufE stays 0. Then csN=1 -> IDLE, aborted=0.
3. Read: 8 posedges with rwBit=1 -> addrWE pulse, then srLoad pulse 1 clk later. misoBufE=1 from the next clk through the 8th negedge, then 0 in DONE.
4. Abort: csN=0, 5 posedges, csN=1 -> aborted pulse 1 clk, IDLE, addrWE/dmWE never asserted. A new csN=0 transaction then completes normally.
5. Simultaneous events: csN rises in the same clk as the 8th data posedge of a write -> no dmWE, aborted=1. sclkPosEdge during READ_SEND -> bitCount unchanged.
6. Overrun: 12 posedges during WRITE_RECV -> exactly one dmWE; pulses in DONE are ignored; state held in DONE until csN=1.
